regfile_scoreboard: RTL and testbench

Parametrised register file for the pipelined MIPS core, with two read ports and two write ports. Write port 0 takes ALU/writeback results and write port 1 takes returning load data. The block provides write-to-read bypass and a per-register pending-load scoreboard, so the hazard unit can stall on registers whose loads are still outstanding. It replaces the single-write-port register file between decode and writeback.

---
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Two-read/two-write register file with write-to-read bypass and a pending-load busy scoreboard.
// Reads are combinational (0 cycles), state updates take 1 edge; no back-pressure, every request is accepted.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              we0;
  logic              we1;
  logic              mark;
  logic              err_set;
  logic              zr1;
  logic              zr2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Requests aimed at the hardwired zero register are dropped before touching any state.
  assign we0  = wen0 && !is_zero(waddr0);
  assign we1  = wen1 && !is_zero(waddr1);
  assign mark = mark_en && !is_zero(mark_addr);
  assign zr1  = is_zero(raddr1);
  assign zr2  = is_zero(raddr2);

  // Set after clear: a load issued in the same cycle its predecessor returns keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (we1) busy_nxt[waddr1] = 1'b0;
    if (mark) busy_nxt[mark_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  assign err_set = (we1 && !busy[waddr1]) ||
                   (mark && busy[mark_addr] && !(we1 && (waddr1 == mark_addr)));

  // Port 0 assigned last so the ALU result wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we1) mem[waddr1] <= wdata1;
      if (we0) mem[waddr0] <= wdata0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
    if (zr1)                           rdata1 = '0;
    else if (wen0 && waddr0 == raddr1) rdata1 = wdata0;
    else if (wen1 && waddr1 == raddr1) rdata1 = wdata1;
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (zr2)                           rdata2 = '0;
    else if (wen0 && waddr0 == raddr2) rdata2 = wdata0;
    else if (wen1 && waddr1 == raddr2) rdata2 = wdata1;
  end

  assign rbusy1 = busy[raddr1] && !(wen1 && (waddr1 == raddr1));
  assign rbusy2 = busy[raddr2] && !(wen1 && (waddr1 == raddr2));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed checks of regfile_scoreboard against a behavioural array/scoreboard model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr0, waddr1, mark_addr;
  logic [31:0] rdata1, rdata2, wdata0, wdata1;
  logic        rbusy1, rbusy2, wen0, wen1, mark_en, err;
  logic [5:0]  busy_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_err;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .busy_cnt(busy_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wen0 && waddr0 == a) return wdata0;
    if (wen1 && waddr1 == a) return wdata1;
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
    return m_busy[a] && !(wen1 && waddr1 == a);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // One clock edge of the architectural rules, applied to the held inputs.
  task automatic m_edge();
    bit w1 = wen1 && waddr1 != 0;
    bit w0 = wen0 && waddr0 != 0;
    bit mk = mark_en && mark_addr != 0;
    if (w1 && !m_busy[waddr1]) m_err = 1'b1;
    if (mk && m_busy[mark_addr] && !(w1 && waddr1 == mark_addr)) m_err = 1'b1;
    if (w1) m_mem[waddr1] = wdata1;
    if (w0) m_mem[waddr0] = wdata0;
    if (w1) m_busy[waddr1] = 1'b0;
    if (mk) m_busy[mark_addr] = 1'b1;
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0; mark_en = 0;
    waddr0 = 0; waddr1 = 0; mark_addr = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check("rdata1", rdata1, m_read(raddr1));
    check("rdata2", rdata2, m_read(raddr2));
    check("rbusy1", rbusy1, m_rbusy(raddr1));
    check("rbusy2", rbusy2, m_rbusy(raddr2));
    @(posedge clk);
    m_edge();
    #1;
    check("busy_cnt", busy_cnt, m_count());
    check("err", err, m_err);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_reset();
    #1;
    check("rst_cnt", busy_cnt, 0);
    check("rst_err", err, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr1 = 5; raddr2 = 0;
    m_reset();
    #1;
    check("init_rdata", rdata1, 0);
    check("init_cnt", busy_cnt, 0);
    check("init_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset clears array, busy and err without a clock edge.
    wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    mark_en = 1; mark_addr = 6;
    wen1 = 1; waddr1 = 9; wdata1 = 32'h1;
    cycle();
    idle(); raddr1 = 5;
    #1;
    check("pre_rst_data", rdata1, 32'hDEADBEEF);
    check("pre_rst_err", err, 1);
    pulse_reset();
    check("rst_data", rdata1, 0);
    raddr1 = 6;
    #1 check("rst_rbusy", rbusy1, 0);

    // Dual write to the same register: ALU data wins.
    wen0 = 1; waddr0 = 7; wdata0 = 32'h11;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h22;
    raddr1 = 7;
    #1 check("dual_byp", rdata1, 32'h11);
    cycle();
    idle();
    #1 check("dual_arr", rdata1, 32'h11);
    pulse_reset();

    // Zero register ignores writes and marks.
    wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    mark_en = 1; mark_addr = 0;
    raddr1 = 0; raddr2 = 0;
    #1 check("zr_byp", rdata1, 0);
    cycle();
    idle();
    #1;
    check("zr_data", rdata1, 0);
    check("zr_busy", rbusy1, 0);
    check("zr_cnt", busy_cnt, 0);
    check("zr_err", err, 0);

    // Mark then clear.
    mark_en = 1; mark_addr = 3; raddr1 = 3;
    #1 check("mark_not_yet", rbusy1, 0);
    cycle();
    idle();
    #1;
    check("mark_busy", rbusy1, 1);
    check("mark_cnt", busy_cnt, 1);
    wen1 = 1; waddr1 = 3; wdata1 = 32'h55;
    #1;
    check("clr_busy", rbusy1, 0);
    check("clr_data", rdata1, 32'h55);
    cycle();
    idle();
    #1;
    check("clr_cnt", busy_cnt, 0);
    check("clr_err", err, 0);

    // Clear and re-mark in the same cycle: set wins, no error.
    mark_en = 1; mark_addr = 4;
    cycle();
    wen1 = 1; waddr1 = 4; wdata1 = 32'h9;
    mark_en = 1; mark_addr = 4; raddr1 = 4;
    cycle();
    idle();
    #1;
    check("coll_data", rdata1, 32'h9);
    check("coll_busy", rbusy1, 1);
    check("coll_cnt", busy_cnt, 1);
    check("coll_err", err, 0);
    pulse_reset();

    // Load return to a non-busy register is sticky until reset.
    wen1 = 1; waddr1 = 9; wdata1 = 32'h7;
    cycle();
    idle();
    #1 check("err_wen1", err, 1);
    for (int k = 0; k < 4; k++) begin
      wen0 = 1; waddr0 = 5'(k + 10); wdata0 = $urandom;
      cycle();
    end
    idle();
    #1 check("err_sticky", err, 1);
    pulse_reset();

    // Double mark without a clear.
    mark_en = 1; mark_addr = 2;
    cycle();
    #1 check("dmark_first", err, 0);
    cycle();
    idle();
    #1 check("dmark_err", err, 1);
    pulse_reset();

    // Random traffic on a narrow address window, biased toward legal load returns.
    for (int c = 0; c < 400; c++) begin
      if (c % 80 == 79) pulse_reset();
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      wen0   = ($urandom_range(0, 2) == 0);
      waddr0 = 5'($urandom_range(0, 7));
      wdata0 = $urandom;
      wen1   = ($urandom_range(0, 2) == 0);
      waddr1 = 5'($urandom_range(0, 7));
      for (int t = 0; t < 6 && !m_busy[waddr1]; t++) waddr1 = 5'($urandom_range(0, 7));
      wdata1 = $urandom;
      mark_en   = ($urandom_range(0, 2) == 0);
      mark_addr = 5'($urandom_range(0, 7));
      for (int t = 0; t < 3 && m_busy[mark_addr]; t++) mark_addr = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
